mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register, and feeds the MEM/WB register directly.
- Non-memory instructions pass through combinationally with zero stall.
- Loads and stores run a request/acknowledge transaction with variable-latency data memory. The stage holds the upstream pipeline via stall_o until the transaction completes.
- Misaligned accesses and memory timeouts are flagged on mem_err_o.

Parameters:
- TIMEOUT, 64: maximum BUSY cycles spent waiting for mem_ack_i before the transaction is aborted.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- MemRead_i  in  1  load instruction present.
- MemWrite_i  in  1  store instruction present.
- RegWrite_i  in  1  register-write control from EX/MEM.
- MemtoReg_i  in  1  writeback-select control from EX/MEM.
- ALUResult_i  in  32  ALU result; also the memory byte address.
- WriteData_i  in  32  store data.
- RDaddr_i  in  5  destination register.
- stall_o  out  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers.
- RegWrite_o  out  1  to MEM/WB RegWrite input.
- MemtoReg_o  out  1  to MEM/WB MemtoReg input.
- Data1_o  out  32  load data to MEM/WB.
- Data2_o  out  32  ALU result to MEM/WB.
- RDaddr_o  out  5  destination register to MEM/WB.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  32  word-aligned byte address.
- mem_wdata_o  out  32  write data.
- mem_ack_i  in  1  memory completion, one-cycle pulse.
- mem_rdata_i  in  32  read data, valid with mem_ack_i.
- mem_err_o  out  1  sticky error flag.
- stall_cnt_o  out  CNT_W  saturating count of cycles with stall_o = 1.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: all registered state and outputs are 0, including mem_req_o, mem_err_o and stall_cnt_o. rst_i mid-transaction returns the FSM to IDLE and drops mem_req_o immediately (asynchronous). No ack is awaited.
- IDLE, MemRead_i = 0 and MemWrite_i = 0:
  - RegWrite_o, MemtoReg_o, RDaddr_o and Data2_o = the corresponding inputs, combinationally.
  - Data1_o = 0, stall_o = 0.
- IDLE, MemRead_i = 1 or MemWrite_i = 1:
  - stall_o = 1 combinationally.
  - RegWrite_o = 0 (bubble); other outputs are don't-care but driven 0.
  - Latch the controls, ALUResult_i, WriteData_i, RDaddr_i, and we = MemWrite_i.
  - If ALUResult_i[1:0] != 0: set mem_err_o, set read data = 0, go to DONE. No request is issued.
  - Otherwise go to BUSY.
  - If MemRead_i and MemWrite_i are both 1, the access is a write.
- BUSY:
  - mem_req_o = 1; mem_we_o, mem_addr_o and mem_wdata_o come from the latches and stay stable until ack.
  - stall_o = 1, RegWrite_o = 0.
  - Wait counter increments every BUSY cycle.
  - On mem_ack_i: latch mem_rdata_i (0 for a write), go to DONE.
  - If the counter reaches TIMEOUT - 1 without ack: set mem_err_o, set read data = 0, go to DONE.
  - Ack and timeout in the same cycle: ack wins and mem_err_o is not set.
- DONE:
  - stall_o = 0, mem_req_o = 0.
  - Outputs come from the latches: RegWrite_o, MemtoReg_o, RDaddr_o, Data2_o = latched ALU result, Data1_o = latched read data.
  - Always go to IDLE next cycle. The still-presented inputs from the stalled instruction are ignored, so the access is never relaunched.
- Minimum memory-op latency is 3 cycles when ack arrives on the first BUSY cycle.
- mem_ack_i outside BUSY is ignored.
- mem_err_o is cleared only by rst_i.
- stall_cnt_o increments on every cycle with stall_o = 1 and saturates at all-ones.
- The wait counter clears on entry to BUSY.

Test Plan:
1. ALU op: RegWrite_i = 1, ALUResult_i = 0x0000_00AA, RDaddr_i = 5 -> same cycle: stall_o = 0, RegWrite_o = 1, Data2_o = 0xAA, RDaddr_o = 5, mem_req_o = 0.
2. Load at 0x100, ack on the 3rd BUSY cycle with rdata 0xDEAD_BEEF:
   - stall_o high for 4 cycles (1 IDLE + 3 BUSY), mem_addr_o = 0x100 held stable.
   - DONE cycle: RegWrite_o = 1, Data1_o = 0xDEADBEEF.
   - stall_cnt_o = 4.
3. Store at 0x20 with data 0x1234, ack on the first BUSY cycle -> mem_we_o = 1, mem_wdata_o = 0x1234; DONE with RegWrite_o = 0; only 1 request beat.
4. Load at 0x102 (misaligned) -> mem_req_o never asserts; mem_err_o = 1 on the next cycle; DONE with Data1_o = 0.
5. Load with no ack (TIMEOUT = 64) -> exactly 64 BUSY cycles, mem_err_o = 1, Data1_o = 0. An ack injected on the 64th BUSY cycle instead completes normally with mem_err_o = 0.
6. rst_i pulsed during BUSY -> mem_req_o drops immediately, state IDLE, all outputs 0; a late mem_ack_i is ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes ALU ops through with no stall, and runs loads/stores as a
// request/acknowledge transaction with variable-latency data memory, stalling upstream until done.
module mem_access_stage #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic [31:0]      ALUResult_i,
  input  logic [31:0]      WriteData_i,
  input  logic [4:0]       RDaddr_i,
  output logic             stall_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic [31:0]      Data1_o,
  output logic [31:0]      Data2_o,
  output logic [4:0]       RDaddr_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic        lat_regwrite, lat_memtoreg, lat_we;
  logic [31:0] lat_addr, lat_wdata, lat_rdata;
  logic [4:0]  lat_rd;

  logic mem_op, misaligned, timeout_hit;

  assign mem_op      = MemRead_i | MemWrite_i;
  assign misaligned  = (ALUResult_i[1:0] != 2'b00);
  assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    next_state  = state;
    stall_o     = 1'b0;
    RegWrite_o  = 1'b0;
    MemtoReg_o  = 1'b0;
    Data1_o     = '0;
    Data2_o     = '0;
    RDaddr_o    = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state)
      IDLE: begin
        if (mem_op) begin
          stall_o    = 1'b1;
          next_state = misaligned ? DONE : BUSY;
        end else begin
          RegWrite_o = RegWrite_i;
          MemtoReg_o = MemtoReg_i;
          Data2_o    = ALUResult_i;
          RDaddr_o   = RDaddr_i;
        end
      end
      BUSY: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = lat_we;
        mem_addr_o  = {lat_addr[31:2], 2'b00};
        mem_wdata_o = lat_wdata;
        if (mem_ack_i || timeout_hit) next_state = DONE;
      end
      DONE: begin
        // Inputs still show the stalled instruction here; ignoring them prevents a relaunch.
        RegWrite_o = lat_regwrite;
        MemtoReg_o = lat_memtoreg;
        Data1_o    = lat_rdata;
        Data2_o    = lat_addr;
        RDaddr_o   = lat_rd;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt     <= '0;
      lat_regwrite <= 1'b0;
      lat_memtoreg <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_rdata    <= '0;
      lat_rd       <= '0;
      mem_err_o    <= 1'b0;
      stall_cnt_o  <= '0;
    end else begin
      if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (mem_op) begin
            lat_regwrite <= RegWrite_i;
            lat_memtoreg <= MemtoReg_i;
            lat_we       <= MemWrite_i;
            lat_addr     <= ALUResult_i;
            lat_wdata    <= WriteData_i;
            lat_rd       <= RDaddr_i;
            lat_rdata    <= '0;
            if (misaligned) mem_err_o <= 1'b1;
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          // Ack has priority over a timeout landing in the same cycle.
          if (mem_ack_i) begin
            lat_rdata <= lat_we ? 32'h0 : mem_rdata_i;
          end else if (timeout_hit) begin
            lat_rdata <= '0;
            mem_err_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized bench for mem_access_stage; a transaction-level model predicts stall
// length, returned data, the sticky error and the stall counter for every operation.
module tb_mem_access_stage;

  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             MemRead_i = 1'b0, MemWrite_i = 1'b0, RegWrite_i = 1'b0, MemtoReg_i = 1'b0;
  logic [31:0]      ALUResult_i = '0, WriteData_i = '0;
  logic [4:0]       RDaddr_i = '0;
  logic             stall_o, RegWrite_o, MemtoReg_o;
  logic [31:0]      Data1_o, Data2_o;
  logic [4:0]       RDaddr_o;
  logic             mem_req_o, mem_we_o;
  logic [31:0]      mem_addr_o, mem_wdata_o;
  logic             mem_ack_i = 1'b0;
  logic [31:0]      mem_rdata_i = '0;
  logic             mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .ALUResult_i(ALUResult_i), .WriteData_i(WriteData_i), .RDaddr_i(RDaddr_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .Data1_o(Data1_o), .Data2_o(Data2_o), .RDaddr_o(RDaddr_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .mem_err_o(mem_err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int  total = 0;
  int  bad   = 0;
  bit  model_err   = 1'b0;
  int  model_stall = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] sat_cnt(input int n);
    return (n > (1 << CNT_W) - 1) ? 64'((1 << CNT_W) - 1) : 64'(n);
  endfunction

  // Non-memory op: one cycle, outputs mirror inputs. An ack pulse here must be ignored.
  task automatic alu_op(input bit rw, input bit mt, input logic [31:0] alu, input logic [4:0] rd,
                        input bit stray_ack);
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    RegWrite_i = rw; MemtoReg_i = mt; ALUResult_i = alu; RDaddr_i = rd;
    WriteData_i = $urandom;
    mem_ack_i = stray_ack; mem_rdata_i = $urandom;
    #1;
    check("alu_stall", stall_o, 0);
    check("alu_regwrite", RegWrite_o, rw);
    check("alu_memtoreg", MemtoReg_o, mt);
    check("alu_data2", Data2_o, alu);
    check("alu_rdaddr", RDaddr_o, rd);
    check("alu_data1", Data1_o, 0);
    check("alu_req", mem_req_o, 0);
    tick();
    mem_ack_i = 1'b0;
    check("alu_stall_cnt", stall_cnt_o, sat_cnt(model_stall));
  endtask

  // Memory op; ack_at is the 1-based BUSY cycle carrying the ack, 0 means memory never answers.
  task automatic mem_op(input bit rd_en, input bit wr_en, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input bit rw, input bit mt,
                        input int ack_at, input logic [31:0] rdata);
    bit          mis, timed_out;
    int          exp_busy, n;
    logic [31:0] exp_data;
    mis       = (addr[1:0] != 2'b00);
    timed_out = !mis && !(ack_at >= 1 && ack_at <= TIMEOUT);
    exp_busy  = mis ? 0 : (timed_out ? TIMEOUT : ack_at);
    exp_data  = (mis || timed_out || wr_en) ? 32'h0 : rdata;
    model_err   = model_err | mis | timed_out;
    model_stall = model_stall + 1 + exp_busy;

    MemRead_i = rd_en; MemWrite_i = wr_en; RegWrite_i = rw; MemtoReg_i = mt;
    ALUResult_i = addr; WriteData_i = wdata; RDaddr_i = rd;
    mem_ack_i = 1'b0;
    #1;
    check("op_idle_stall", stall_o, 1);
    check("op_idle_bubble", RegWrite_o, 0);
    check("op_idle_req", mem_req_o, 0);
    tick();
    n = 0;
    while (mem_req_o === 1'b1 && n < TIMEOUT + 4) begin
      n++;
      check("busy_stall", stall_o, 1);
      check("busy_bubble", RegWrite_o, 0);
      check("busy_addr", mem_addr_o, {addr[31:2], 2'b00});
      check("busy_we", mem_we_o, wr_en);
      check("busy_wdata", mem_wdata_o, wdata);
      mem_ack_i   = (n == ack_at);
      mem_rdata_i = mem_ack_i ? rdata : $urandom;
      tick();
      mem_ack_i = 1'b0;
    end
    check("busy_cycles", 64'(n), 64'(exp_busy));
    check("done_stall", stall_o, 0);
    check("done_req", mem_req_o, 0);
    check("done_regwrite", RegWrite_o, rw);
    check("done_memtoreg", MemtoReg_o, mt);
    check("done_rdaddr", RDaddr_o, rd);
    check("done_data2", Data2_o, addr);
    check("done_data1", Data1_o, exp_data);
    check("done_err", mem_err_o, model_err);
    check("done_stall_cnt", stall_cnt_o, sat_cnt(model_stall));
    tick();
    check("after_done_req", mem_req_o, 0);
  endtask

  task automatic reset_idle_checks(input string tag);
    check({tag, "_stall"}, stall_o, 0);
    check({tag, "_req"}, mem_req_o, 0);
    check({tag, "_regwrite"}, RegWrite_o, 0);
    check({tag, "_memtoreg"}, MemtoReg_o, 0);
    check({tag, "_data1"}, Data1_o, 0);
    check({tag, "_data2"}, Data2_o, 0);
    check({tag, "_rdaddr"}, RDaddr_o, 0);
    check({tag, "_err"}, mem_err_o, 0);
    check({tag, "_stall_cnt"}, stall_cnt_o, 0);
  endtask

  initial begin
    // Reset state with all inputs idle.
    #2;
    reset_idle_checks("reset");
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Plain ALU op, then a stray ack outside BUSY.
    alu_op(1'b1, 1'b0, 32'h0000_00AA, 5'd5, 1'b0);
    alu_op(1'b1, 1'b1, 32'h1357_9BDF, 5'd17, 1'b1);

    // Load with ack on the third BUSY cycle; stall count reaches 4.
    mem_op(1'b1, 1'b0, 32'h100, 32'h0, 5'd9, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
    check("load_stall_cnt_4", stall_cnt_o, 4);

    // Store with immediate ack: a single request beat.
    mem_op(1'b0, 1'b1, 32'h20, 32'h1234, 5'd0, 1'b0, 1'b0, 1, 32'hCAFE_F00D);

    // Misaligned load: no request, sticky error, zero data.
    mem_op(1'b1, 1'b0, 32'h102, 32'h0, 5'd3, 1'b1, 1'b1, 1, 32'h5555_AAAA);

    // Read+write together counts as a write.
    mem_op(1'b1, 1'b1, 32'h44, 32'hA5A5_0F0F, 5'd7, 1'b1, 1'b0, 2, 32'h1111_2222);

    // Randomized mix of ALU ops and memory ops with random latency.
    for (int i = 0; i < 30; i++) begin
      int          kind;
      logic [31:0] a;
      int          lat;
      kind = int'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      lat  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      if (kind == 0)
        alu_op(1'($urandom), 1'($urandom), a, 5'($urandom), 1'($urandom));
      else
        mem_op(kind != 2, kind != 1, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
               lat, $urandom);
    end

    // Reset in the middle of a BUSY wait.
    MemRead_i = 1'b1; MemWrite_i = 1'b0; RegWrite_i = 1'b1; MemtoReg_i = 1'b1;
    ALUResult_i = 32'h40; RDaddr_i = 5'd12;
    tick();
    tick();
    check("pre_reset_req", mem_req_o, 1);
    rst_i = 1'b1;
    #1;
    check("reset_async_req", mem_req_o, 0);
    MemRead_i = 1'b0; RegWrite_i = 1'b0; MemtoReg_i = 1'b0; ALUResult_i = '0; RDaddr_i = '0;
    #1;
    reset_idle_checks("midreset");
    model_err   = 1'b0;
    model_stall = 0;
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    tick();
    rst_i = 1'b0;
    tick();
    mem_ack_i = 1'b0;
    #1;
    check("late_ack_req", mem_req_o, 0);
    check("late_ack_stall", stall_o, 0);
    check("late_ack_data1", Data1_o, 0);
    check("late_ack_stall_cnt", stall_cnt_o, 0);
    tick();

    // Ack on the last allowed BUSY cycle completes cleanly, then a full timeout.
    mem_op(1'b1, 1'b0, 32'h200, 32'h0, 5'd4, 1'b1, 1'b1, TIMEOUT, 32'h0BAD_F00D);
    check("ack_at_limit_err", mem_err_o, 0);
    mem_op(1'b1, 1'b0, 32'h204, 32'h0, 5'd6, 1'b1, 1'b1, 0, 32'h7777_7777);
    check("timeout_err", mem_err_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so a stuck design still terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
